// File: rtl/insn_encoder_pkg.sv
// Shared constants for the RV32I field encoder: instruction format selects
// (also used as the decoder's ext_op select), major opcodes, and a helper
// for sign-uniformity tests on immediates.
package insn_encoder_pkg;

  // Format select encoding; 3'b110 and 3'b111 are reserved
  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_U = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // True when bits [31:msb] of v are all ones or all zeros, i.e. v is a
  // correctly sign-extended (msb+1)-bit quantity.
  function automatic logic imm_uniform(input logic [31:0] v, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/insn_encoder_pack.sv
// insn_pack: purely combinational packer from decoded RV32I fields to a
// 32-bit instruction word, plus an immediate range-violation flag.
// Macro IMM_RANGE_CHECK_EN enables the range check; otherwise the flag is 0
// and out-of-range immediates are silently truncated.
module insn_pack
  import insn_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_err_o
);

  // Scatter fields into the word layout of the selected format; reserved
  // selects fall through to the R layout
  always_comb begin
    word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
    case (fmt_i)
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                       rd_i, opcode_i};
      default: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates that would lose information when packed
  always_comb begin
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: range_err_o = !imm_uniform(imm_i, 11);
      FMT_B:        range_err_o = !imm_uniform(imm_i, 12) || imm_i[0];
      FMT_J:        range_err_o = !imm_uniform(imm_i, 20) || imm_i[0];
      FMT_U:        range_err_o = |imm_i[11:0];
      FMT_R:        range_err_o = 1'b0;
      default:      range_err_o = 1'b1;
    endcase
  end
`else
  assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: accepts decoded instruction fields over valid/ready, packs
// them into RV32I words and streams them to IMEM at consecutive word
// addresses through a single output register stage.
// Macro IMM_RANGE_CHECK_EN: out-of-range immediates are dropped and set a
// sticky err_o; when undefined err_o is tied low.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [ADDR_W-1:0]           base_addr_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [2:0]                  fmt_i,
  input  logic [6:0]                  opcode_i,
  input  logic [2:0]                  funct3_i,
  input  logic [6:0]                  funct7_i,
  input  logic [4:0]                  rd_i,
  input  logic [4:0]                  rs1_i,
  input  logic [4:0]                  rs2_i,
  input  logic [31:0]                 imm_i,
  output logic                        wr_en_o,
  input  logic                        wr_ready_i,
  output logic [ADDR_W-1:0]           wr_addr_o,
  output logic [31:0]                 wr_data_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        busy_o,
  output logic                        full_o,
  output logic                        err_o
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     acc_q, acc_d;     // words accepted for writing this session

  logic [31:0] packed_word;
  logic        range_err;
  logic        accept, good, complete, start_ok;

  insn_pack u_pack (
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .imm_i       (imm_i),
    .word_o      (packed_word),
    .range_err_o (range_err)
  );

  // Ready only in RUN, and only if the output register is empty or emptying
  assign in_ready_o = (state_q == S_RUN) && (!wr_en_q || wr_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign good       = accept && !range_err;
  assign complete   = wr_en_q && wr_ready_i;
  assign start_ok   = (state_q == S_IDLE) && start_i;

  // Session control; a stop in the same cycle as an accept still takes the word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (stop_i)                                   state_d = S_DRAIN;
        else if (good && acc_q == CW'(DEPTH - 1))     state_d = S_FULL;
      end
      S_DRAIN: if (!wr_en_q) state_d = S_IDLE;
      S_FULL:  if (stop_i)   state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register, write address and counters; a completing write and a
  // new accept in one cycle reload the register at the advanced address
  always_comb begin
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    count_d   = count_q;
    acc_d     = acc_q;
    if (start_ok) begin
      addr_d  = base_addr_i;
      count_d = '0;
      acc_d   = '0;
    end
    if (complete) begin
      wr_en_d = 1'b0;
      addr_d  = addr_q + ADDR_W'(4);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end
    if (good) begin
      wr_en_d   = 1'b1;
      wr_data_d = packed_word;
      acc_d     = acc_q + CW'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_q, err_d;

  // Sticky error: set by a rejected immediate, cleared by a new session
  always_comb begin
    err_d = err_q;
    if (start_ok)               err_d = 1'b0;
    if (accept && range_err)    err_d = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign wr_addr_o = addr_q;
  assign count_o   = count_q;
  assign busy_o    = (state_q != S_IDLE);
  assign full_o    = (state_q == S_FULL);

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder (DEPTH=4, ADDR_W=12): directed
// cases from the encoding rules plus randomized sessions checked against an
// arithmetic encoder model and an expected-write queue.
module tb_insn_encoder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, in_valid, in_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [2:0]        fmt;
  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic              wr_en, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [CW-1:0]     count;
  logic              busy, full, err;

  always #5 clk = ~clk;

  insn_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .base_addr_i(base_addr), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .wr_en_o(wr_en), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .count_o(count), .busy_o(busy), .full_o(full),
    .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  logic [ADDR_W-1:0] model_base;
  int model_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder: place each field by shift-and-mask arithmetic
  function automatic logic [31:0] ref_encode(input int unsigned f, input int unsigned op,
      input int unsigned f3, input int unsigned f7, input int unsigned rdv,
      input int unsigned r1, input int unsigned r2, input int unsigned i);
    int unsigned w;
    case (f)
      0: w = ((i & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op;
      1: w = (i & 32'hFFFF_F000) | (rdv << 7) | op;
      2: w = (((i >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
           | ((i & 31) << 7) | op;
      3: w = (((i >> 12) & 1) << 31) | (((i >> 5) & 63) << 25) | (r2 << 20)
           | (r1 << 15) | (f3 << 12) | (((i >> 1) & 15) << 8)
           | (((i >> 11) & 1) << 7) | op;
      4: w = (((i >> 20) & 1) << 31) | (((i >> 1) & 1023) << 21)
           | (((i >> 11) & 1) << 20) | (((i >> 12) & 255) << 12) | (rdv << 7) | op;
      default: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op;
    endcase
    return w;
  endfunction

  // Reference range rule: is the immediate representable in its format?
  function automatic bit ref_bad(input int unsigned f, input int unsigned i);
    int s;
    s = $signed(i);
`ifdef IMM_RANGE_CHECK_EN
    case (f)
      0, 2:    return (s < -2048) || (s > 2047);
      3:       return (s < -4096) || (s > 4095) || ((i & 1) != 0);
      4:       return (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((i & 1) != 0);
      1:       return (i & 32'hFFF) != 0;
      5:       return 1'b0;
      default: return 1'b1;
    endcase
`else
    return (f > 7) && (s == 0);
`endif
  endfunction

  // Write monitor: each completing write must be the oldest expected one
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      $display("write addr=%h data=%h", wr_addr, wr_data);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%h expected=none", wr_data);
      end
      if (exp_q.size() != 0) begin
        check("wr_addr", wr_addr, exp_q[0].addr);
        check("wr_data", wr_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
    model_base = b; model_acc = 0;
  endtask

  // Offer one field set; push the expected write if the model says it is legal
  task automatic send(input int unsigned f, input int unsigned op, input int unsigned f3,
      input int unsigned f7, input int unsigned rdv, input int unsigned r1,
      input int unsigned r2, input int unsigned i, input bit with_stop,
      input int bound, input bit must, output bit taken, output int waited);
    wr_t e;
    fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
    rd = 5'(rdv); rs1 = 5'(r1); rs2 = 5'(r2); imm = i;
    in_valid = 1'b1; taken = 1'b0; waited = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (in_ready) begin taken = 1'b1; break; end
      waited++;
    end
    if (taken) begin
      stop = with_stop;
      if (!ref_bad(f, i)) begin
        e.addr = model_base + ADDR_W'(4 * model_acc);
        e.data = ref_encode(f, op, f3, f7, rdv, r1, r2, i);
        exp_q.push_back(e);
        model_acc++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; stop = 1'b0;
    if (must) check("accept_timeout", {31'b0, taken}, 32'd1);
  endtask

  task automatic do_stop(input bit assert_stop);
    if (assert_stop) begin stop = 1'b1; tick(); stop = 1'b0; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("stop_idle", {31'b0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tk;
    int wt, n_taken, n;
    logic [31:0] ri;
    bit ws;
    rst_n = 1'b0; start = 0; stop = 0; in_valid = 0; base_addr = '0;
    fmt = 0; opcode = 0; funct3 = 0; funct7 = 0; rd = 0; rs1 = 0; rs2 = 0;
    imm = 0; wr_ready = 1'b1; model_base = '0; model_acc = 0;
    tick(); tick();
    @(negedge clk);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_addr", {20'b0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick(); rst_n = 1'b1; tick();

    // ADDI x1,x0,5 at 0x100
    do_start(12'h100);
    check("busy_run", {31'b0, busy}, 32'd1);
    check("addi_ref", ref_encode(0, 'h13, 0, 0, 1, 0, 0, 5), 32'h0050_0093);
    send(0, 'h13, 0, 0, 1, 0, 0, 5, 0, 10, 1, tk, wt);
    tick(); tick(); @(negedge clk);
    check("addi_count", {29'b0, count}, 32'd1);
    do_stop(1);

    // LUI then SW back to back, then BEQ and JAL to fill the session
    do_start(12'h200);
    send(1, 'h37, 0, 0, 2, 0, 0, 32'h1234_5000, 0, 10, 1, tk, wt);
    send(2, 'h23, 2, 0, 0, 2, 3, 8, 0, 10, 1, tk, wt);
    check("b2b_ready_wait", wt, 32'd0);
    send(3, 'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 10, 1, tk, wt);
    send(4, 'h6F, 0, 0, 1, 0, 0, 32'h0000_0800, 0, 10, 1, tk, wt);
    @(negedge clk);
    check("full_after_4", {31'b0, full}, 32'd1);
    check("ready_when_full", {31'b0, in_ready}, 32'd0);
    do_stop(1);
    check("beq_ref", ref_encode(3, 'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC), 32'hFE00_0EE3);
    check("jal_ref", ref_encode(4, 'h6F, 0, 0, 1, 0, 0, 32'h800), 32'h0010_00EF);

    // IMEM back-pressure with a second word pending
    do_start(12'h300);
    wr_ready = 1'b0;
    send(0, 'h13, 0, 0, 5, 6, 0, 32'h7FF, 0, 10, 1, tk, wt);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_data", wr_data, ref_encode(0, 'h13, 0, 0, 5, 6, 0, 32'h7FF));
      check("stall_addr", {20'b0, wr_addr}, 32'h300);
      check("stall_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    wr_ready = 1'b1;
    send(5, 'h33, 7, 'h20, 9, 10, 11, 0, 0, 10, 1, tk, wt);
    do_stop(1);

    // Six words offered into a 4-deep session starting near the top of memory
    do_start(12'hFF8);
    n_taken = 0;
    for (int j = 0; j < 6; j++) begin
      send(0, 'h13, 0, 0, j + 1, 0, 0, j, 0, 5, 0, tk, wt);
      n_taken += int'(tk);
    end
    check("full_taken", n_taken, 32'd4);
    check("full_flag", {31'b0, full}, 32'd1);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_count", {29'b0, count}, 32'd4);
    do_stop(1);

    // Reset in mid-session drops the pending word
    do_start(12'h400);
    wr_ready = 1'b0;
    send(0, 'h13, 0, 0, 1, 0, 0, 1, 0, 10, 1, tk, wt);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_wr_en", {31'b0, wr_en}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    wr_ready = 1'b1;
    tick(); rst_n = 1'b1; tick(); tick();
    check("midrst_count", {29'b0, count}, 32'd0);

`ifdef IMM_RANGE_CHECK_EN
    // Out-of-range I immediate is swallowed and flagged
    do_start(12'h500);
    send(0, 'h13, 0, 0, 1, 0, 0, 2048, 0, 10, 1, tk, wt);
    tick(); @(negedge clk);
    check("rng_err_set", {31'b0, err}, 32'd1);
    check("rng_count", {29'b0, count}, 32'd0);
    send(0, 'h13, 0, 0, 1, 0, 0, 5, 0, 10, 1, tk, wt);
    tick(); tick(); @(negedge clk);
    check("rng_count_after", {29'b0, count}, 32'd1);
    check("rng_err_sticky", {31'b0, err}, 32'd1);
    do_stop(1);
    do_start(12'h600);
    @(negedge clk);
    check("rng_err_clear", {31'b0, err}, 32'd0);
    do_stop(1);
`else
    // Reserved format packs as R and never raises err_o
    do_start(12'h500);
    send(6, 'h33, 3, 'h5A, 4, 5, 6, 32'hFFFF_FFFF, 0, 10, 1, tk, wt);
    tick(); @(negedge clk);
    check("resv_err", {31'b0, err}, 32'd0);
    do_stop(1);
`endif

    // Randomized sessions
    for (int s = 0; s < 20; s++) begin
      do_start(12'($urandom) & 12'hFFC);
      n = $urandom_range(1, 4);
      ws = 1'b0;
      for (int j = 0; j < n; j++) begin
        ri = $urandom;
        if ($urandom_range(0, 1) == 1) ri = {{20{ri[11]}}, ri[11:1], 1'b0};
        ws = (j == n - 1) && (n < 4) && ($urandom_range(0, 1) == 1);
        send($urandom_range(0, 7), $urandom & 'h7F, $urandom & 7, $urandom & 'h7F,
             $urandom & 31, $urandom & 31, $urandom & 31, ri, ws, 10, 1, tk, wt);
        if ($urandom_range(0, 1) == 1 && !ws) tick();
      end
      do_stop(!ws);
      check("sess_count", {29'b0, count}, model_acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
